// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
//   tx_state_e    - transmitter FSM state encoding
//   byte_t        - one line byte
//   clks_per_bit  - system clocks per serial bit (integer division)
//   DATA_BITS, STOP_BITS - frame constants
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef logic [DATA_BITS-1:0] byte_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// uart_tx_stream_if: byte valid/ready stream into the UART transmitter.
//   data  - byte offered by the producer
//   valid - data is offered
//   ready - consumer can take a byte this edge
interface uart_tx_stream_if;

    uart_pkg::byte_t data;
    logic            valid;
    logic            ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sync_fifo_8.sv
// sync_fifo_8: single-clock byte FIFO, synchronous active-low reset.
//   push/din      - write din when push and not full
//   pop/dout_c    - dout_c shows the head; pop advances it when not empty
//   full/empty    - registered occupancy flags
//   full_next_c, empty_next_c - flags as they will be after this edge
module sync_fifo_8 #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout_c,
    output logic       full,
    output logic       empty,
    output logic       full_next_c,
    output logic       empty_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    // Overflow/underflow protection; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok      = push && !full_q;
        pop_ok       = pop && !empty_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_next_c  = (count_d == CNT_W'(DEPTH));
        empty_next_c = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_next_c;
            empty_q  <= empty_next_c;
        end
    end

    // Storage needs no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

    assign dout_c = mem[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered UART transmitter, LSB first, idle-high line.
//   clk, rst_n - system clock, synchronous active-low reset
//   s          - byte stream in (uart_tx_stream_if.slave: data/valid/ready)
//   txd        - serial output, registered
//   busy       - FIFO non-empty or frame in progress, registered
// Build option: define UART_TX_PARITY_EN for 8E1 frames (even parity bit
// between data and stop); left undefined, frames are 8N1.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 12000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_stream_if.slave   s,
    output logic              txd,
    output logic              busy
);

    localparam int unsigned CPB   = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    byte_t            shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic  push_c, pop_c, bit_end_c;
    byte_t fifo_dout_c;
    logic  fifo_full, fifo_empty, fifo_full_next_c, fifo_empty_next_c;

    assign push_c = s.valid && ready_q && !fifo_full;

    sync_fifo_8 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push_c),
        .din          (s.data),
        .pop          (pop_c),
        .dout_c       (fifo_dout_c),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .full_next_c  (fifo_full_next_c),
        .empty_next_c (fifo_empty_next_c)
    );

    // Next-state, baud counter, shifter and registered line/status values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pop_c     = 1'b0;
        txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_end_c = (cnt_q == CNT_W'(CPB - 1));

        // Counter idles at 0 and reloads at every bit boundary.
        if (state_q == TX_IDLE) cnt_d = '0;
        else                    cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout_c;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout_c;
`endif
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end_c) begin
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end_c) state_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                // Chain straight into the next start bit when data waits.
                if (bit_end_c) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_dout_c;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout_c;
`endif
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the state being entered so txd is a clean flop.
        case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: txd_d = parity_d;
`endif
            default:   txd_d = 1'b1;
        endcase

        busy_d  = !fifo_empty_next_c || (state_d != TX_IDLE);
        ready_d = !fifo_full_next_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign s.ready = ready_q;
    assign txd     = txd_q;
    assign busy    = busy_q;

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Buffered 8N1 UART transmitter: the serial source for links terminated by the team's `uart_rx_8n1`. It accepts bytes over a valid/ready stream into an internal FIFO and serialises them LSB-first on `txd`. Bit timing comes from an internal clock-enable counter on the single system clock; there is no derived clock domain. It sits between the FFT result formatter and the board TX pin.

## Interface
Parameters:
- `CLOCK_FREQ`, 12000000: system clock frequency in Hz.
- `BAUD_RATE`, 19200: line rate in bit/s.
- `FIFO_DEPTH`, 16: byte slots. Must be a power of two, at least 2.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `data`  in  8: byte to send.
- `valid`  in  1: `data` is offered.
- `ready`  out  1: FIFO can take a byte.
- `txd`  out  1: serial line; idles high.
- `busy`  out  1: FIFO non-empty or a frame is in progress.

## Operation
- `CLKS_PER_BIT` = CLOCK_FREQ / BAUD_RATE, integer division. The default is 625.
- Every bit lasts exactly `CLKS_PER_BIT` cycles. The baud counter reloads at each bit boundary and is held at 0 in IDLE.
- A byte is written when `valid && ready` is true at a rising edge. `data` must be stable only at that edge.
- `ready` = !full. It is registered.
- FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `txd`=0 for one bit.
  - DATA: `txd` = `shift[0]`, then shift right. After 8 bits go to PARITY (if enabled) or STOP.
  - PARITY: `txd` = even parity bit, for one bit. Only exists with the macro defined.
  - STOP: `txd`=1 for one bit. At the final cycle of the bit, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- FIFO boundaries:
  - Full: `ready`=0 and writes are ignored. The byte is not lost to the producer because the handshake is not completed.
  - Simultaneous push and pop when full: the pop frees a slot, but `ready` reasserts only the cycle after.
  - Simultaneous push and pop when empty: not possible, because a pop requires a non-empty FIFO the previous cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and `txd` returns high the cycle after the reset edge. A truncated frame on the line is acceptable.

## Timing
- Values during and immediately after reset:
  - `txd`=1, `busy`=0, `ready`=0, FIFO empty, FSM in IDLE.
  - `ready` rises on the first edge with `rst_n`=1.
- Latency with an empty FIFO and the FSM in IDLE:
  - Byte accepted at edge N.
  - FSM pops at edge N+1.
  - `txd` falls after edge N+1.
  - `busy` rises after edge N.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity. Back-to-back frames are contiguous.
- `busy` falls in the same cycle that `txd` starts the idle high following the last stop bit.
- `txd` is driven from a flop, so the output is glitch-free.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - The transmitted bit is the XOR of the 8 data bits (even parity).
  - The frame is 8E1, 11 bits.
- Undefined: the PARITY state and its logic are absent, and the frame is 8N1, 10 bits.

## Structure
- `uart_pkg`:
  - FSM state enum (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`).
  - Function `clks_per_bit(clock_freq, baud_rate)`.
  - Frame constants (`DATA_BITS`=8, `STOP_BITS`=1).
- Sub-module `sync_fifo_8`: single-clock byte FIFO with push/pop/full/empty. It is reusable later by the RX rework.
- Top level: FSM, baud counter, shift register, parity.

## Test plan
- Reset release, then send 0x55 with defaults: `txd` is low for 625 cycles, then 1,0,1,0,1,0,1,0 at 625 cycles each, then high. `busy` is high for exactly 6250 cycles plus the 1-cycle pop latency.
- Send 0xA3 then 0x0F, with `valid` held: the frames are contiguous with no idle gap. A UART-model decoder checks 0xA3, 0x0F.
- Push 17 bytes with `FIFO_DEPTH`=16 while the line is busy: `ready` drops after 16 entries are resident. The 17th byte is held until a pop and then accepted. All 17 bytes are decoded in order.
- `UART_TX_PARITY_EN` defined, send 0x07: the parity bit is 1 and the frame is 6875 cycles. Send 0x03: the parity bit is 0.
- Reset asserted mid-DATA of 0xFF with 3 bytes queued: `txd`=1 the next cycle, `busy`=0, and after release no further frames are emitted.
- CLOCK_FREQ=100 and BAUD_RATE=10 (`CLKS_PER_BIT`=10), send 0x80: every bit is 10 cycles and bit 7 is high on the 9th bit slot.
